// File: rtl/multiplicador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multiplicador_pkg
// Purpose  : Shared constants and state type for the binary-to-BCD converter
//            sitting between the multiplier core and the display multiplexer.
// Contents : BCD_DIGITS  - number of BCD digits produced
//            BCD_W       - width of the packed BCD code
//            BLANK_DIGIT - digit code rendered as all segments off
//            conv_state_t- converter state encoding
// Revision : 1.0 - initial release
// ============================================================================
package multiplicador_pkg;

    localparam int         BCD_DIGITS  = 3;
    localparam int         BCD_W       = 4 * BCD_DIGITS;
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

endpackage : multiplicador_pkg
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adjust
// Purpose  : Combinational double-dabble correction cell: a BCD digit of
//            5 or more gets 3 added so the following left shift carries
//            correctly into the next decimal digit.
// Ports    : i_digit [3:0] - scratch digit before correction
//            o_digit [3:0] - corrected digit
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/bin_to_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_converter
// Purpose  : Sequential double-dabble converter. Converts the signed product
//            from the multiplier core into a 3-digit BCD magnitude and a sign
//            bit, one shift/add-3 step per clock, and holds the result stable
//            for the display between conversions.
// Ports    : clk      - system clock
//            reset    - asynchronous active-low reset
//            start    - one-cycle request, product sampled on the same edge
//            product  - signed two's-complement input [IN_W-1:0]
//            busy     - conversion in progress (start ignored while high)
//            done     - one-cycle pulse when BCD_code/sign update
//            BCD_code - [11:8] hundreds, [7:4] tens, [3:0] units
//            sign     - 1 = negative result
// Options  : LEADING_ZERO_BLANK_EN - replace leading zero hundreds/tens with
//            BLANK_DIGIT when the result is published. Units never blanked.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_converter
    import multiplicador_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IN_W-1:0]  product,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] BCD_code,
    output logic             sign
);

    localparam int CNT_W = $clog2(IN_W + 1);

    conv_state_t        r_state;
    conv_state_t        w_state_nxt;

    logic [IN_W-1:0]    r_mag;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign_pend;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd_code;
    logic               r_sign;

    logic               w_accept;
    logic               w_last;
    logic [IN_W-1:0]    w_abs;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W+IN_W-1:0] w_shift_all;
    logic [BCD_W-1:0]   w_bcd_final;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

    // Read as an unsigned IN_W-bit value, the negation of -2^(IN_W-1)
    // yields exactly 2^(IN_W-1), so the magnitude needs no extra bit here.
    assign w_abs = product[IN_W-1] ? (~product + IN_W'(1)) : product;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // {scratch, mag} shifted as one register; the magnitude MSB enters
    // the units digit.
    assign w_shift_all = {w_adj, r_mag} << 1;

    always_comb begin
        w_bcd_final = w_shift_all[BCD_W+IN_W-1:IN_W];
`ifdef LEADING_ZERO_BLANK_EN
        if (w_bcd_final[11:8] == 4'd0) begin
            w_bcd_final[11:8] = BLANK_DIGIT;
            if (w_bcd_final[7:4] == 4'd0) begin
                w_bcd_final[7:4] = BLANK_DIGIT;
            end
        end
`endif
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mag       <= '0;
            r_scratch   <= '0;
            r_cnt       <= '0;
            r_sign_pend <= 1'b0;
            r_done      <= 1'b0;
            r_bcd_code  <= '0;
            r_sign      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                // Only a negative input can set the MSB, and such a value is
                // never zero, so zero always reports positive.
                r_sign_pend <= product[IN_W-1];
                r_mag       <= w_abs;
                r_scratch   <= '0;
                r_cnt       <= CNT_W'(IN_W);
            end else if (r_state == SHIFT) begin
                r_scratch <= w_shift_all[BCD_W+IN_W-1:IN_W];
                r_mag     <= w_shift_all[IN_W-1:0];
                r_cnt     <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_bcd_code <= w_bcd_final;
                    r_sign     <= r_sign_pend;
                    r_done     <= 1'b1;
                end
            end
        end
    end

    assign busy     = (r_state == SHIFT);
    assign done     = r_done;
    assign BCD_code = r_bcd_code;
    assign sign     = r_sign;

endmodule : bin_to_bcd_converter
`default_nettype wire
